mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store unit between a pipeline and a word-wide RAM.
// A request is accepted in IDLE, the RAM is strobed in that same cycle, read data is captured
// RAM_LATENCY cycles later, and the aligned/extended result is held until consumed.
// Optional build macro: MEM_MISALIGN_TRAP_EN adds rsp_fault_o and suppresses misaligned
// H/W accesses instead of issuing them with truncated byte masks.

module mem_access_ctrl #(
  parameter int unsigned word_width  = 32, // only 32 is supported
  parameter int unsigned RAM_LATENCY = 1   // legal range 1..3
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [word_width-1:0] req_addr_i,
  input  logic [word_width-1:0] req_wdata_i,
  output logic                  ram_en_o,
  output logic [word_width-1:0] ram_addr_o,
  output logic [3:0]            ram_we_o,
  output logic [word_width-1:0] ram_wdata_o,
  input  logic [word_width-1:0] ram_rdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [word_width-1:0] rsp_rdata_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  rsp_fault_o
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Byte-lane mask for an access, before any misalignment handling. Lanes pushed past
  // bit 3 by the offset are dropped by the 4-bit result width.
  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] base;
    case (funct3)
      3'b000, 3'b100: base = 4'b0001;
      3'b001, 3'b101: base = 4'b0011;
      default:        base = 4'b1111; // W, and the illegal encodings behave as W
    endcase
    return base << off;
  endfunction

  // Mask the addressed lanes, right-align them and apply the size/sign extension.
  function automatic logic [31:0] load_result(input logic [2:0]  funct3,
                                              input logic [1:0]  off,
                                              input logic [31:0] rdata);
    logic [3:0]  mask;
    logic [31:0] bits;
    logic [31:0] v;
    mask = byte_mask(funct3, off);
    for (int i = 0; i < 4; i++) begin
      bits[8*i +: 8] = {8{mask[i]}};
    end
    v = (rdata & bits) >> {off, 3'b000};
    case (funct3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'h0, v[7:0]};
      3'b101:  return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  // Only signed H and word-class accesses are checked; byte accesses can never be misaligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic is_word;
    is_word = !(funct3 inside {3'b000, 3'b001, 3'b100, 3'b101});
    return ((funct3 == 3'b001) && off[0]) || (is_word && (off != 2'b00));
  endfunction
`endif

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mis_q;
  logic        rsp_fault_q;
`endif

  logic        accept;
  logic        req_mis;
  logic [31:0] load_data_d;

  assign accept = (state_q == StIdle) && req_valid_i && !reset_i;

`ifdef MEM_MISALIGN_TRAP_EN
  assign req_mis = is_misaligned(req_funct3_i, req_addr_i[1:0]);
`else
  assign req_mis = 1'b0;
`endif

  // RAM strobe and write lanes are driven straight from the request in the accept cycle.
  always_comb begin
    req_ready_o = (state_q == StIdle) && !reset_i;
    ram_en_o    = accept && !req_mis;
    ram_we_o    = 4'b0000;
    if (accept && req_we_i && !req_mis) begin
      ram_we_o = byte_mask(req_funct3_i, req_addr_i[1:0]);
    end
    ram_addr_o  = {req_addr_i[31:2], 2'b00};
    ram_wdata_o = req_wdata_i << {req_addr_i[1:0], 3'b000};
  end

  // Result to be captured at the end of WAIT; stores and trapped ops return zero.
  always_comb begin
    load_data_d = we_q ? 32'h0 : load_result(funct3_q, off_q, ram_rdata_i);
`ifdef MEM_MISALIGN_TRAP_EN
    if (mis_q) begin
      load_data_d = 32'h0;
    end
`endif
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
      rsp_fault_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            off_q    <= req_addr_i[1:0];
            cnt_q    <= 2'(RAM_LATENCY);
            state_q  <= StWait;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q    <= req_mis;
`endif
          end
        end
        StWait: begin
          if (cnt_q == 2'd1) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_data_d;
            cnt_q       <= 2'd0;
            state_q     <= StResp;
`ifdef MEM_MISALIGN_TRAP_EN
            rsp_fault_q <= mis_q;
`endif
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Response outputs read as zero while reset is held, even before the registers clear.
  always_comb begin
    rsp_valid_o = rsp_valid_q && !reset_i;
    rsp_rdata_o = reset_i ? 32'h0 : rsp_rdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
    rsp_fault_o = rsp_fault_q && !reset_i;
`endif
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed RV32I cases, backpressure, reset in WAIT,
// and randomized loads/stores scored against a byte-addressed reference memory.
// Build with +define+MEM_MISALIGN_TRAP_EN to cover the misalignment trap variant.

module tb_mem_access_ctrl;

  localparam int unsigned LAT = 3;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ram_en;
  logic [31:0] ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        rsp_fault;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0]  ref_mem [256];
  logic [31:0] ram_mem [64];
  logic [31:0] pipe [3];

  logic [31:0] obs_rdata;
  logic [3:0]  obs_we;
  logic [31:0] obs_wdata;
  logic        obs_en;
  logic        obs_fault;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .word_width (32),
    .RAM_LATENCY(LAT)
  ) u_dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_funct3_i(req_funct3),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .rsp_fault_o (rsp_fault)
`endif
  );

  // RAM with LAT-cycle read pipeline; idle cycles shift garbage so mistimed captures show up.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) ram_mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      pipe[0] <= ram_mem[ram_addr[7:2]];
    end else begin
      pipe[0] <= $urandom;
    end
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign ram_rdata = pipe[LAT-1];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned op_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] addr);
    bit cond;
    cond = ((f3 == 3'b001) && addr[0]) || ((op_size(f3) == 4) && (addr[1:0] != 2'b00));
    return TrapEn && cond;
  endfunction

  task automatic garbage_req();
    req_valid  = 1'($urandom);
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // One complete transaction: accept, wait, hold for 'hold' cycles, then handshake.
  task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int unsigned hold);
    int unsigned off;
    int unsigned size;
    int unsigned n;
    int          idx;
    bit          mis;
    logic [3:0]  exp_we;
    logic [31:0] exp_rd;
    off    = int'(addr[1:0]);
    size   = op_size(f3);
    mis    = misaligned(f3, addr);
    exp_we = 4'b0000;
    exp_rd = 32'h0;
    for (int unsigned j = 0; j < size; j++) begin
      if (off + j < 4) begin
        idx = int'(addr[7:0]) + int'(j);
        if (we) exp_we[off+j] = 1'b1;
        else exp_rd = exp_rd | (32'(ref_mem[idx]) << (8 * j));
      end
    end
    if (!we && f3 == 3'b000 && exp_rd[7])  exp_rd[31:8]  = 24'hFFFFFF;
    if (!we && f3 == 3'b001 && exp_rd[15]) exp_rd[31:16] = 16'hFFFF;
    if (mis) begin
      exp_we = 4'b0000;
      exp_rd = 32'h0;
    end

    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    #1;
    obs_en    = ram_en;
    obs_we    = ram_we;
    obs_wdata = ram_wdata;
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    check_eq("ram_en_accept", 32'(ram_en), 32'(!mis));
    check_eq("ram_we_accept", 32'(ram_we), 32'(exp_we));
    if (!mis) begin
      check_eq("ram_addr", ram_addr, addr & 32'hFFFF_FFFC);
      if (we) check_eq("ram_wdata", ram_wdata, wdata << (8 * off));
    end
    if (we && !mis) begin
      for (int unsigned j = 0; j < size; j++) begin
        if (off + j < 4) ref_mem[int'(addr[7:0]) + int'(j)] = wdata[8*j +: 8];
      end
    end
    tick();

    garbage_req();
    n = 0;
    while (!rsp_valid && n < LAT + 4) begin
      #1;
      check_eq("ram_en_wait", 32'(ram_en), 32'd0);
      check_eq("req_ready_wait", 32'(req_ready), 32'd0);
      tick();
      garbage_req();
      n++;
    end
    check_eq("latency", n, LAT);

    repeat (hold) begin
      #1;
      check_eq("rsp_valid_hold", 32'(rsp_valid), 32'd1);
      check_eq("rsp_rdata_hold", rsp_rdata, exp_rd);
      check_eq("req_ready_resp", 32'(req_ready), 32'd0);
      check_eq("ram_en_resp", 32'(ram_en), 32'd0);
      tick();
      garbage_req();
    end

    rsp_ready = 1'b1;
    #1;
    obs_rdata = rsp_rdata;
    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("rsp_rdata", rsp_rdata, exp_rd);
`ifdef MEM_MISALIGN_TRAP_EN
    obs_fault = rsp_fault;
    check_eq("rsp_fault", 32'(rsp_fault), 32'(mis));
`else
    obs_fault = 1'b0;
`endif
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    #1;
    check_eq("rsp_valid_after", 32'(rsp_valid), 32'd0);
    check_eq("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h100;
    req_wdata  = 32'h1234_5678;
    rsp_ready  = 1'b0;
    obs_rdata  = 32'h0;
    obs_we     = 4'h0;
    obs_wdata  = 32'h0;
    obs_en     = 1'b0;
    obs_fault  = 1'b0;
    tick();
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_ram_en", 32'(ram_en), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(req_ready), 32'd1);
    check_eq("post_rst_valid", 32'(rsp_valid), 32'd0);

    // Fill the 16-word window used by every later access.
    for (int w = 0; w < 16; w++) do_op(1'b1, 3'b010, 32'h100 + 32'(4 * w), $urandom, 0);

    do_op(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0);
    check_eq("sw_we", 32'(obs_we), 32'hF);
    check_eq("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 5);
    check_eq("lw_data", obs_rdata, 32'hDEAD_BEEF);

    do_op(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 0);
    check_eq("sb_we", 32'(obs_we), 32'h8);
    check_eq("sb_wdata", obs_wdata, 32'hA500_0000);
    do_op(1'b0, 3'b000, 32'h103, 32'h0, 1);
    check_eq("lb_data", obs_rdata, 32'hFFFF_FFA5);
    do_op(1'b0, 3'b100, 32'h103, 32'h0, 0);
    check_eq("lbu_data", obs_rdata, 32'h0000_00A5);

    do_op(1'b1, 3'b001, 32'h102, 32'h0000_8001, 0);
    do_op(1'b0, 3'b001, 32'h102, 32'h0, 2);
    check_eq("lh_data", obs_rdata, 32'hFFFF_8001);
    do_op(1'b0, 3'b101, 32'h102, 32'h0, 0);
    check_eq("lhu_data", obs_rdata, 32'h0000_8001);

    do_op(1'b0, 3'b010, 32'h101, 32'h0, 0);
    if (TrapEn) begin
      check_eq("trap_lw_fault", 32'(obs_fault), 32'd1);
      check_eq("trap_lw_rdata", obs_rdata, 32'd0);
      check_eq("trap_lw_en", 32'(obs_en), 32'd0);
    end

    // Reset while in WAIT: the op is dropped and no response appears.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h104;
    tick();
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check_eq("rst_wait_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_wait_en", 32'(ram_en), 32'd0);
    check_eq("rst_wait_ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst_wait_idle", 32'(req_ready), 32'd1);
    repeat (LAT + 3) begin
      check_eq("rst_wait_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end

    for (int i = 0; i < 300; i++) begin
      do_op(1'($urandom), 3'($urandom), 32'h100 + 32'($urandom_range(0, 63)), $urandom,
            $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
